// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PucCPU program-counter sequencer: widths, opcodes, state enum.
`default_nettype none

package pc_sequencer_pkg;

   localparam int DEF_PC_WIDTH     = 8;
   localparam int DEF_OPCODE_WIDTH = 4;

   localparam logic [DEF_OPCODE_WIDTH-1:0] OP_NOP  = 4'h0;
   localparam logic [DEF_OPCODE_WIDTH-1:0] OP_JMP  = 4'h1;
   localparam logic [DEF_OPCODE_WIDTH-1:0] OP_JZ   = 4'h2;
   localparam logic [DEF_OPCODE_WIDTH-1:0] OP_CALL = 4'h3;
   localparam logic [DEF_OPCODE_WIDTH-1:0] OP_RET  = 4'h4;
   localparam logic [DEF_OPCODE_WIDTH-1:0] OP_RST  = 4'h5;
   localparam logic [DEF_OPCODE_WIDTH-1:0] OP_HALT = 4'h6;

   typedef enum logic [2:0] {
      ST_FLUSH = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_HALT  = 3'd3,
      ST_FAULT = 3'd4
   } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/return_depth_counter.sv
// Tracks live return-stack entries; saturates at both ends so the stack never over/underflows.
`default_nettype none

module return_depth_counter #(
   parameter int STACK_DEPTH = 16,
   parameter int DEPTH_W     = $clog2(STACK_DEPTH) + 1
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               clear_i,
   input  logic               inc_i,
   input  logic               dec_i,
   output logic [DEPTH_W-1:0] depth_o,
   output logic               at_full_o,
   output logic               at_empty_o
);

   localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(STACK_DEPTH);

   logic [DEPTH_W-1:0] depth_q;
   logic [DEPTH_W-1:0] depth_d;

   assign at_full_o  = (depth_q >= FULL);
   assign at_empty_o = (depth_q == '0);
   assign depth_o    = depth_q;

   always_comb begin
      depth_d = depth_q;
      if (clear_i) begin
         depth_d = '0;
      end else if (inc_i && !at_full_o) begin
         depth_d = depth_q + DEPTH_W'(1);
      end else if (dec_i && !at_empty_o) begin
         depth_d = depth_q - DEPTH_W'(1);
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         depth_q <= '0;
      end else begin
         depth_q <= depth_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// PucCPU program-counter sequencer: fetch/exec control, next-PC selection and return-stack handshake.
`default_nettype none

module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int PC_WIDTH     = DEF_PC_WIDTH,
   parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH,
   parameter int STACK_DEPTH  = 16
) (
   input  logic                         clock_i,
   input  logic                         reset_i,
   output logic                         fetch_req_o,
   output logic [PC_WIDTH-1:0]          pc_o,
   input  logic                         instr_valid_i,
   input  logic [OPCODE_WIDTH-1:0]      opcode_i,
   input  logic [PC_WIDTH-1:0]          operand_i,
   input  logic                         zero_flag_i,
   output logic                         call_o,
   output logic                         ret_o,
   output logic                         stack_reset_o,
   output logic [PC_WIDTH-1:0]          called_from_o,
   input  logic [PC_WIDTH-1:0]          return_to_i,
   output logic [$clog2(STACK_DEPTH):0] depth_o,
   output logic                         halted_o,
   output logic                         fault_o
);

   seq_state_t                state_q;
   logic [PC_WIDTH-1:0]       pc_q;
   logic [PC_WIDTH-1:0]       called_from_q;
   logic [PC_WIDTH-1:0]       operand_q;
   logic [OPCODE_WIDTH-1:0]   op_q;
   logic                      fetch_req_q;
   logic                      call_q;
   logic                      ret_q;
   logic                      stack_reset_q;
   logic                      halted_q;
   logic                      fault_q;
   logic                      at_full;
   logic                      at_empty;
   logic [PC_WIDTH-1:0]       pc_inc;

   assign pc_inc = pc_q + PC_WIDTH'(1);

   // Pulses are decided when leaving FETCH so they appear registered for the whole EXEC cycle.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= ST_FLUSH;
         pc_q          <= '0;
         called_from_q <= '0;
         operand_q     <= '0;
         op_q          <= '0;
         fetch_req_q   <= 1'b0;
         call_q        <= 1'b0;
         ret_q         <= 1'b0;
         stack_reset_q <= 1'b1;
         halted_q      <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         call_q        <= 1'b0;
         ret_q         <= 1'b0;
         stack_reset_q <= 1'b0;
         case (state_q)
            ST_FLUSH: begin
               pc_q        <= '0;
               fetch_req_q <= 1'b1;
               state_q     <= ST_FETCH;
            end
            ST_FETCH: begin
               if (instr_valid_i) begin
                  op_q        <= opcode_i;
                  operand_q   <= operand_i;
                  fetch_req_q <= 1'b0;
                  state_q     <= ST_EXEC;
                  case (opcode_i)
                     OPCODE_WIDTH'(OP_CALL): begin
                        if (!at_full) begin
                           call_q        <= 1'b1;
                           called_from_q <= pc_q;
                        end
                     end
                     OPCODE_WIDTH'(OP_RET):  ret_q         <= !at_empty;
                     OPCODE_WIDTH'(OP_RST):  stack_reset_q <= 1'b1;
                     default: ;
                  endcase
               end
            end
            ST_EXEC: begin
               fetch_req_q <= 1'b1;
               state_q     <= ST_FETCH;
               case (op_q)
                  OPCODE_WIDTH'(OP_JMP): pc_q <= operand_q;
                  OPCODE_WIDTH'(OP_JZ):  pc_q <= zero_flag_i ? operand_q : pc_inc;
                  OPCODE_WIDTH'(OP_CALL): begin
                     if (call_q) begin
                        pc_q <= operand_q;
                     end else begin
                        fetch_req_q <= 1'b0;
                        fault_q     <= 1'b1;
                        state_q     <= ST_FAULT;
                     end
                  end
                  OPCODE_WIDTH'(OP_RET): begin
                     if (ret_q) begin
                        pc_q <= return_to_i;
                     end else begin
                        fetch_req_q <= 1'b0;
                        fault_q     <= 1'b1;
                        state_q     <= ST_FAULT;
                     end
                  end
                  OPCODE_WIDTH'(OP_RST): pc_q <= '0;
                  OPCODE_WIDTH'(OP_HALT): begin
                     fetch_req_q <= 1'b0;
                     halted_q    <= 1'b1;
                     state_q     <= ST_HALT;
                  end
                  default: pc_q <= pc_inc;
               endcase
            end
            ST_HALT:  state_q <= ST_HALT;
            ST_FAULT: state_q <= ST_FAULT;
            default:  state_q <= ST_FLUSH;
         endcase
      end
   end

   return_depth_counter #(
      .STACK_DEPTH (STACK_DEPTH),
      .DEPTH_W     ($clog2(STACK_DEPTH) + 1)
   ) u_depth (
      .clock_i    (clock_i),
      .reset_i    (reset_i),
      .clear_i    (stack_reset_q),
      .inc_i      (call_q),
      .dec_i      (ret_q),
      .depth_o    (depth_o),
      .at_full_o  (at_full),
      .at_empty_o (at_empty)
   );

   assign fetch_req_o   = fetch_req_q;
   assign pc_o          = pc_q;
   assign call_o        = call_q;
   assign ret_o         = ret_q;
   assign stack_reset_o = stack_reset_q;
   assign called_from_o = called_from_q;
   assign halted_o      = halted_q;
   assign fault_o       = fault_q;

endmodule

`default_nettype wire
